// File: rtl/imem_loader.sv
// imem_loader: receives a program over a byte stream (16-bit big-endian word
// count, big-endian 32-bit words, XOR checksum byte), writes it into the
// instruction memory and holds the core until a verified program is present.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int WL_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [7:0]          r_len_hi;
  logic [15:0]         r_count;
  logic [31:0]         r_word;
  logic [1:0]          r_byte_idx;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [7:0]          r_chk;

  logic                w_xfer;
  logic                w_idle;
  logic                w_start;
  logic [15:0]         w_count;
  logic                w_len_bad;
  logic                w_last_word;
  logic                w_word_done;

  assign w_xfer      = in_valid & in_ready;
  assign w_idle      = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);
  assign w_start     = load_req & w_idle;
  assign w_count     = {r_len_hi, in_data};
  // A zero-length program or one larger than the memory is rejected up front,
  // which is also what keeps the word index from ever passing DEPTH-1.
  assign w_len_bad   = (w_count == 16'd0) || ({1'b0, w_count} > 17'(DEPTH));
  assign w_last_word = ((16'(r_word_idx) + 16'd1) == r_count);
  assign w_word_done = (r_state == S_DATA) && w_xfer && (r_byte_idx == 2'd3);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (load_req) w_next = S_LEN_HI;
      S_LEN_HI:              if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO:              if (w_xfer) w_next = w_len_bad ? S_ERR : S_DATA;
      S_DATA:                if (w_word_done && w_last_word) w_next = S_CHK;
      S_CHK:                 if (w_xfer) w_next = (in_data == r_chk) ? S_DONE : S_ERR;
      default:               w_next = S_IDLE;
    endcase
  end

  // in_ready is the only output decoded straight from the current state
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA, S_CHK: in_ready = 1'b1;
      default:                           in_ready = 1'b0;
    endcase
  end

  // Data capture: length bytes and word assembly (no reset needed)
  always_ff @(posedge clk) begin
    if (r_state == S_LEN_HI && w_xfer) r_len_hi <= in_data;
    if (r_state == S_LEN_LO && w_xfer) r_count  <= w_count;
    if (r_state == S_DATA && w_xfer) begin
      case (r_byte_idx)
        2'd0:    r_word[31:24] <= in_data;
        2'd1:    r_word[23:16] <= in_data;
        2'd2:    r_word[15:8]  <= in_data;
        default: r_word[7:0]   <= in_data;
      endcase
    end
  end

  // Registered outputs and session control counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_hold    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_chk        <= '0;
    end else begin
      mem_we <= 1'b0;
      if (w_start) begin
        done         <= 1'b0;
        err          <= 1'b0;
        words_loaded <= '0;
        r_byte_idx   <= '0;
        r_word_idx   <= '0;
        r_chk        <= '0;
        core_hold    <= 1'b1;
        busy         <= 1'b1;
      end
      if (r_state == S_LEN_LO && w_xfer && w_len_bad) begin
        busy <= 1'b0;
        err  <= 1'b1;
      end
      if (r_state == S_DATA && w_xfer) begin
        r_chk      <= r_chk ^ in_data;
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      // The completed word is written on the cycle after its 4th byte while
      // the stream keeps flowing; the final word's strobe lands in CHK.
      if (w_word_done) begin
        mem_we       <= 1'b1;
        mem_addr     <= r_word_idx;
        mem_wdata    <= {r_word[31:8], in_data};
        r_word_idx   <= r_word_idx + ADDR_W'(1);
        words_loaded <= words_loaded + WL_W'(1);
      end
      if (r_state == S_CHK && w_xfer) begin
        busy <= 1'b0;
        if (in_data == r_chk) begin
          done      <= 1'b1;
          core_hold <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams and checks memory
// writes and status outputs against hand-computed expectations.
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_req;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  logic [7:0]        s_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_hold(core_hold),
    .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] wa(input int i);
    if (i < wa_q.size()) return 32'(wa_q[i]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wd(input int i);
    if (i < wd_q.size()) return wd_q[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic start_load();
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit req);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    load_req = req;
    g = 0;
    while (!in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) chk("send_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    load_req = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1 in_data = 8'($urandom);
    end
  endtask

  task automatic run_stream(input int gap, input int req_at);
    foreach (s_q[i]) send(s_q[i], gap, (i == req_at));
    repeat (3) @(negedge clk);
  endtask

  task automatic build1(input logic [7:0] cs);
    s_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
            8'hDE, 8'hAD, 8'hBE, 8'hEF, cs};
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_nwr"},   32'(wa_q.size()), 32'd2);
    chk({tag, "_a0"},    wa(0), 32'd0);
    chk({tag, "_d0"},    wd(0), 32'h1234_5678);
    chk({tag, "_a1"},    wa(1), 32'd1);
    chk({tag, "_d1"},    wd(1), 32'hDEAD_BEEF);
  endtask

  task automatic check_done(input string tag, input int nwords);
    chk({tag, "_done"},  32'(done), 32'd1);
    chk({tag, "_err"},   32'(err), 32'd0);
    chk({tag, "_hold"},  32'(core_hold), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_rdy"},   32'(in_ready), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(nwords));
  endtask

  task automatic check_err(input string tag);
    chk({tag, "_err"},   32'(err), 32'd1);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_hold"},  32'(core_hold), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_rdy"},   32'(in_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  x;
    int          seen_rdy;
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",   32'(in_ready), 32'd0);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    chk("rst_hold",  32'(core_hold), 32'd1);
    rst = 1'b0;

    // Test 1: two-word load, back-to-back
    clear_log();
    start_load();
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_rdy",  32'(in_ready), 32'd1);
    build1(8'h2A);
    run_stream(0, -1);
    check_two_writes("t1");
    check_done("t1", 2);

    // Test 2: bad checksum
    clear_log();
    start_load();
    build1(8'h00);
    run_stream(0, -1);
    check_two_writes("t2");
    check_err("t2");

    // Test 3a: zero length
    clear_log();
    start_load();
    s_q = '{8'h00, 8'h00};
    run_stream(0, -1);
    chk("t3a_nwr", 32'(wa_q.size()), 32'd0);
    check_err("t3a");

    // Test 3b: length 1025
    clear_log();
    start_load();
    s_q = '{8'h04, 8'h01};
    run_stream(0, -1);
    chk("t3b_nwr", 32'(wa_q.size()), 32'd0);
    check_err("t3b");

    // Test 3c: full 1024-word program
    clear_log();
    start_load();
    s_q = '{8'h04, 8'h00};
    x = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'(i * 3), 8'(i), 8'(i >> 2), 8'h5A};
      s_q.push_back(w[31:24]); s_q.push_back(w[23:16]);
      s_q.push_back(w[15:8]);  s_q.push_back(w[7:0]);
      x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    s_q.push_back(x);
    run_stream(0, -1);
    w = {8'(1023 * 3), 8'(1023), 8'(1023 >> 2), 8'h5A};
    chk("t3c_nwr",   32'(wa_q.size()), 32'd1024);
    chk("t3c_alast", wa(1023), 32'd1023);
    chk("t3c_dlast", wd(1023), w);
    chk("t3c_d5",    wd(5), {8'd15, 8'd5, 8'd1, 8'h5A});
    check_done("t3c", 1024);

    // Test 4: valid every third cycle with junk data in between
    clear_log();
    start_load();
    build1(8'h2A);
    run_stream(2, -1);
    check_two_writes("t4");
    check_done("t4", 2);

    // Test 5: reset after five data bytes
    clear_log();
    start_load();
    s_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDE};
    run_stream(0, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy",  32'(busy), 32'd0);
    chk("t5_words", 32'(words_loaded), 32'd0);
    chk("t5_hold",  32'(core_hold), 32'd1);
    chk("t5_done",  32'(done), 32'd0);
    chk("t5_rdy",   32'(in_ready), 32'd0);
    s_q = '{8'hAD, 8'hBE, 8'hEF, 8'h2A, 8'h11, 8'h22};
    seen_rdy = 0;
    foreach (s_q[i]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = s_q[i];
      if (in_ready) seen_rdy++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_rdy_seen", 32'(seen_rdy), 32'd0);
    chk("t5_nwr",      32'(wa_q.size()), 32'd1);
    chk("t5_a0",       wa(0), 32'd0);
    chk("t5_d0",       wd(0), 32'h1234_5678);

    // Test 6: load_req during DATA is ignored; load_req in DONE restarts
    clear_log();
    start_load();
    build1(8'h2A);
    run_stream(0, 4);
    check_two_writes("t6");
    check_done("t6", 2);
    clear_log();
    start_load();
    @(negedge clk);
    chk("t6r_done", 32'(done), 32'd0);
    chk("t6r_hold", 32'(core_hold), 32'd1);
    chk("t6r_busy", 32'(busy), 32'd1);
    s_q = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
    run_stream(0, -1);
    chk("t6r_nwr", 32'(wa_q.size()), 32'd1);
    chk("t6r_a0",  wa(0), 32'd0);
    chk("t6r_d0",  wd(0), 32'hCAFE_BABE);
    check_done("t6r", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writes a program into the 1024-word instruction memory that the fetch stage reads.
- Receives a byte stream over a valid/ready handshake: 16-bit word count, then big-endian 32-bit instruction words, then an XOR checksum byte.
- Generates instruction-memory write strobes and holds the core (core_hold) until a complete, verified program is loaded.
- Implements the "code" mode of the core; the "execute" mode begins when core_hold deasserts.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 1024, maximum number of words; must satisfy DEPTH <= 2^ADDR_W.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- load_req  input  1  single-cycle pulse that starts a load session.
- in_valid  input  1  in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs on in_valid & in_ready at the clock edge.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  word address being written.
- mem_wdata  output  32  word being written.
- core_hold  output  1  stalls the core while 1.
- busy  output  1  session in progress.
- done  output  1  load completed and checksum matched.
- err  output  1  load aborted.
- words_loaded  output  ADDR_W+1  number of words written in the current session.

Behaviour:
- Reset:
  - State IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0, words_loaded=0.
  - core_hold=1.
- Outputs: all outputs are registered, except in_ready, which is decoded from the current state.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- IDLE / DONE / ERR:
  - in_ready=0.
  - load_req goes to LEN_HI and, in the same cycle, clears done, err, words_loaded, the byte index, the word index and the checksum accumulator; it also sets core_hold=1 and busy=1.
  - DONE holds done=1, core_hold=0. ERR holds err=1, core_hold=1.
- LEN_HI, LEN_LO:
  - in_ready=1. Each accepted byte forms count = {hi, lo}.
  - After LEN_LO: if count==0 or count>DEPTH, go to ERR (busy=0). Otherwise go to DATA.
  - Length bytes are not included in the checksum.
- DATA:
  - in_ready=1. A 2-bit byte index selects the byte lane; the first byte goes to [31:24] and the fourth to [7:0].
  - Every accepted byte is XORed into the checksum accumulator.
  - On the 4th byte: in the next cycle mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = the assembled word. The word index and words_loaded then increment.
  - Throughput is one byte per cycle with no stall during the write cycle.
  - After the 4th byte of word count-1, go to CHK. The final write strobe coincides with the first CHK cycle.
- CHK:
  - in_ready=1. One byte is accepted.
  - If it equals the accumulator, go to DONE (busy=0). Otherwise go to ERR (busy=0).
- Handshake rules:
  - in_data is ignored when in_valid=0.
  - Gaps of any length between bytes are allowed and do not alter results.
- Ignored pulses: load_req while busy=1 is ignored.
- Error handling: words already written are not rolled back on ERR.
- rst mid-session:
  - Next edge goes to IDLE with reset output values; no further mem_we.
  - A strobe pending for a completed word is dropped.
- Address bound: mem_addr never exceeds DEPTH-1, because count is bounded and the word index never wraps within a session.

Test Plan:
1. Two-word load, bytes 00 02 12 34 56 78 DE AD BE EF 2A, back-to-back valid -> exactly two mem_we pulses, (0, 0x12345678) then (1, 0xDEADBEEF); done=1, core_hold=0, words_loaded=2, err=0.
2. Same stream with checksum byte 0x00 -> both writes occur; err=1, done=0, core_hold=1, in_ready=0 afterwards.
3. Length 00 00 -> err=1 after the 2nd byte with no mem_we. Length 04 01 (1025) -> err=1 with no mem_we. Length 04 00 with full data and correct checksum -> last write at mem_addr=1023, done=1.
4. Test 1 stream with in_valid high only every 3rd cycle and random in_data while invalid -> identical writes and identical final outputs.
5. Test 1 stream with rst asserted for one cycle after 5 data bytes -> one write at addr 0 occurs. After rst: IDLE, words_loaded=0, core_hold=1, no further mem_we. Remaining stream bytes are ignored (in_ready=0).
6. load_req pulsed during DATA -> ignored, load completes normally. load_req in DONE -> done=0, core_hold=1, busy=1, and a new load writes from addr 0.
